// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer
//   Expands one arbiter instruction into the byte-engine command sequence of a
//   register-pointer transaction on the temperature sensor, then reports the
//   read data or error back toward the UART side.
//
// Ports
//   clk, reset        clock, asynchronous active-low reset
//   valid_instr[1:0]  00 none, 01 queued, 11 default poll (sampled in CAPTURE)
//   i2c_mode[7:0]     transaction mode, only [2:0] decoded
//   i2c_address[7:0]  sensor register pointer
//   i2c_data[15:0]    write data, high byte first
//   i2c_ready         one-cycle offer to the arbiter (it pops on every ready)
//   cmd_valid/op/byte command request to the byte engine, held until cmd_done
//   cmd_done/nack     engine completion pulse, NACK qualifier for WRITEs
//   rx_byte[7:0]      read byte, valid with cmd_done on READs
//   result_*          one-cycle result pulse with held data/default/error
//   busy              high outside IDLE/GAP
module i2c_txn_sequencer #(
    parameter logic [6:0] DEV_ADDR = 7'h48,
    parameter int         POLL_GAP = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  valid_instr,
    input  logic [7:0]  i2c_mode,
    input  logic [7:0]  i2c_address,
    input  logic [15:0] i2c_data,
    output logic        i2c_ready,
    output logic        cmd_valid,
    output logic [2:0]  cmd_op,
    output logic [7:0]  cmd_byte,
    input  logic        cmd_done,
    input  logic        cmd_nack,
    input  logic [7:0]  rx_byte,
    output logic        result_valid,
    output logic [15:0] result_data,
    output logic        result_default,
    output logic        result_error,
    output logic        busy
);

    localparam logic [2:0] OP_START     = 3'd0;
    localparam logic [2:0] OP_RESTART   = 3'd1;
    localparam logic [2:0] OP_WRITE     = 3'd2;
    localparam logic [2:0] OP_READ_ACK  = 3'd3;
    localparam logic [2:0] OP_READ_NACK = 3'd4;
    localparam logic [2:0] OP_STOP      = 3'd5;

    localparam bit         HAS_GAP  = (POLL_GAP > 0);
    localparam logic [15:0] GAP_LAST = (POLL_GAP > 0) ? 16'(POLL_GAP - 1) : 16'd0;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CAPTURE, ST_NEXT, ST_CMD, ST_REPORT, ST_GAP
    } state_t;

    // Position in the command sequence; SQ_DONE means "report now".
    typedef enum logic [3:0] {
        SQ_START, SQ_DEVW, SQ_PTR, SQ_WD_HI, SQ_WD_LO, SQ_RSTART,
        SQ_DEVR, SQ_RD_HI, SQ_RD_LO, SQ_STOP, SQ_DONE
    } step_t;

    state_t      state;
    step_t       step;
    step_t       after_step;
    logic [2:0]  mode_q;
    logic [7:0]  addr_q;
    logic [15:0] data_q;
    logic [15:0] rd_q;
    logic [15:0] gap_cnt;
    logic        is_default;
    logic        err_q;
    logic [2:0]  nxt_op;
    logic [7:0]  nxt_byte;
    logic        mode_illegal;
    logic        unused_mode_hi;

    assign unused_mode_hi = ^i2c_mode[7:3];
    assign mode_illegal   = (i2c_mode[2:0] > 3'b100);

    // Command presented for the current step.
    always_comb begin
        nxt_op   = OP_STOP;
        nxt_byte = 8'h00;
        case (step)
            SQ_START:  nxt_op = OP_START;
            SQ_DEVW:   begin nxt_op = OP_WRITE; nxt_byte = {DEV_ADDR, 1'b0}; end
            SQ_PTR:    begin nxt_op = OP_WRITE; nxt_byte = addr_q; end
            SQ_WD_HI:  begin nxt_op = OP_WRITE; nxt_byte = data_q[15:8]; end
            SQ_WD_LO:  begin nxt_op = OP_WRITE; nxt_byte = data_q[7:0]; end
            SQ_RSTART: nxt_op = OP_RESTART;
            SQ_DEVR:   begin nxt_op = OP_WRITE; nxt_byte = {DEV_ADDR, 1'b1}; end
            SQ_RD_HI:  nxt_op = OP_READ_ACK;
            SQ_RD_LO:  nxt_op = OP_READ_NACK;
            default:   nxt_op = OP_STOP;
        endcase
    end

    // Successor step on a clean (ACKed) completion.
    always_comb begin
        after_step = SQ_DONE;
        case (step)
            SQ_START:  after_step = SQ_DEVW;
            SQ_DEVW:   after_step = SQ_PTR;
            SQ_PTR: begin
                case (mode_q)
                    3'b001, 3'b010: after_step = SQ_RSTART;
                    3'b011:         after_step = SQ_WD_LO;
                    3'b100:         after_step = SQ_WD_HI;
                    default:        after_step = SQ_STOP;
                endcase
            end
            SQ_WD_HI:  after_step = SQ_WD_LO;
            SQ_WD_LO:  after_step = SQ_STOP;
            SQ_RSTART: after_step = SQ_DEVR;
            SQ_DEVR:   after_step = (mode_q == 3'b001) ? SQ_RD_HI : SQ_RD_LO;
            SQ_RD_HI:  after_step = SQ_RD_LO;
            SQ_RD_LO:  after_step = SQ_STOP;
            default:   after_step = SQ_DONE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            step           <= SQ_START;
            mode_q         <= 3'd0;
            addr_q         <= 8'h00;
            data_q         <= 16'h0000;
            rd_q           <= 16'h0000;
            gap_cnt        <= 16'h0000;
            is_default     <= 1'b0;
            err_q          <= 1'b0;
            i2c_ready      <= 1'b0;
            cmd_valid      <= 1'b0;
            cmd_op         <= 3'd0;
            cmd_byte       <= 8'h00;
            result_valid   <= 1'b0;
            result_data    <= 16'h0000;
            result_default <= 1'b0;
            result_error   <= 1'b0;
            busy           <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Every entry into IDLE already raised ready; only the
                    // first cycle after reset arrives here with it low.
                    if (i2c_ready) begin
                        i2c_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_CAPTURE;
                    end else begin
                        i2c_ready <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (valid_instr == 2'b00) begin
                        i2c_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        mode_q     <= i2c_mode[2:0];
                        addr_q     <= i2c_address;
                        data_q     <= i2c_data;
                        is_default <= valid_instr[1];
                        err_q      <= mode_illegal;
                        rd_q       <= 16'h0000;
                        step       <= mode_illegal ? SQ_DONE : SQ_START;
                        state      <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    // Bubble cycle between commands; also the report launch.
                    if (step == SQ_DONE) begin
                        result_valid   <= 1'b1;
                        result_data    <= err_q ? 16'h0000 : rd_q;
                        result_default <= is_default;
                        result_error   <= err_q;
                        state          <= ST_REPORT;
                    end else begin
                        cmd_valid <= 1'b1;
                        cmd_op    <= nxt_op;
                        cmd_byte  <= nxt_byte;
                        state     <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (cmd_done) begin
                        cmd_valid <= 1'b0;
                        if (step == SQ_RD_HI) rd_q[15:8] <= rx_byte;
                        if (step == SQ_RD_LO) rd_q[7:0]  <= rx_byte;
                        // A NACKed write abandons the rest but still closes the bus.
                        if (cmd_op == OP_WRITE && cmd_nack) begin
                            err_q <= 1'b1;
                            step  <= SQ_STOP;
                        end else begin
                            step <= after_step;
                        end
                        state <= ST_NEXT;
                    end
                end
                ST_REPORT: begin
                    busy <= 1'b0;
                    if (is_default && HAS_GAP) begin
                        gap_cnt <= 16'h0000;
                        state   <= ST_GAP;
                    end else begin
                        i2c_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt   <= 16'h0000;
                        i2c_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
module tb_i2c_txn_sequencer;

    localparam int PG = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  valid_instr;
    logic [7:0]  i2c_mode;
    logic [7:0]  i2c_address;
    logic [15:0] i2c_data;
    logic        i2c_ready;
    logic        cmd_valid;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_byte;
    logic        cmd_done;
    logic        cmd_nack;
    logic [7:0]  rx_byte;
    logic        result_valid;
    logic [15:0] result_data;
    logic        result_default;
    logic        result_error;
    logic        busy;

    i2c_txn_sequencer #(.DEV_ADDR(7'h48), .POLL_GAP(PG)) dut (
        .clk(clk), .reset(reset),
        .valid_instr(valid_instr), .i2c_mode(i2c_mode),
        .i2c_address(i2c_address), .i2c_data(i2c_data),
        .i2c_ready(i2c_ready),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_byte(cmd_byte),
        .cmd_done(cmd_done), .cmd_nack(cmd_nack), .rx_byte(rx_byte),
        .result_valid(result_valid), .result_data(result_data),
        .result_default(result_default), .result_error(result_error),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [2:0] op; logic [7:0] b; } cmd_t;
    typedef struct packed { logic [15:0] d; logic def; logic err; } res_t;

    cmd_t exp_cmd[$];
    res_t exp_res[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        vectors++;
        miscompares++;
        $error("FAIL %s: timed out waiting for DUT", tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [2:0] op, input logic [7:0] b);
        exp_cmd.push_back('{op: op, b: b});
    endtask

    // Arbiter side: wait for the offer, present the instruction, confirm the
    // offer lasted one cycle. Returns in the CAPTURE cycle.
    task automatic offer(input logic [1:0] vi, input logic [7:0] m,
                         input logic [7:0] a, input logic [15:0] d);
        int n = 0;
        while (!i2c_ready && n < 200) begin tick(); n++; end
        if (!i2c_ready) timeout_fail("offer");
        valid_instr = vi; i2c_mode = m; i2c_address = a; i2c_data = d;
        tick();
        chk("ready_one_cycle", 32'(i2c_ready), 32'd0);
    endtask

    task automatic wait_cmd();
        int   n = 0;
        cmd_t e;
        while (!cmd_valid && n < 40) begin tick(); n++; end
        if (!cmd_valid) timeout_fail("cmd_valid");
        else if (exp_cmd.size() == 0) timeout_fail("unexpected_cmd");
        else begin
            e = exp_cmd.pop_front();
            chk("cmd_op", 32'(cmd_op), 32'(e.op));
            chk("cmd_byte", 32'(cmd_byte), 32'(e.b));
        end
    endtask

    // Byte engine side: accept one command, optionally stall, then complete.
    task automatic serve(input logic nack, input logic [7:0] rx, input int hold);
        logic       stable = 1'b1;
        logic [2:0] op0;
        logic [7:0] b0;
        wait_cmd();
        op0 = cmd_op; b0 = cmd_byte;
        if (hold > 0) begin
            repeat (hold) begin
                tick();
                if (!(cmd_valid === 1'b1 && cmd_op === op0 && cmd_byte === b0)) stable = 1'b0;
            end
            chk("cmd_stable_during_stall", 32'(stable), 32'd1);
        end
        cmd_done = 1'b1; cmd_nack = nack; rx_byte = rx;
        tick();
        cmd_done = 1'b0; cmd_nack = 1'b0; rx_byte = 8'h00;
        chk("cmd_valid_drop", 32'(cmd_valid), 32'd0);
    endtask

    task automatic check_result();
        int   n = 0;
        res_t e;
        while (!result_valid && n < 40) begin tick(); n++; end
        if (!result_valid) timeout_fail("result_valid");
        else if (exp_res.size() == 0) timeout_fail("unexpected_result");
        else begin
            e = exp_res.pop_front();
            chk("result_data", 32'(result_data), 32'(e.d));
            chk("result_default", 32'(result_default), 32'(e.def));
            chk("result_error", 32'(result_error), 32'(e.err));
        end
    endtask

    task automatic ready_distance(input string tag, input int exp_n);
        int n = 0;
        while (!i2c_ready && n < 200) begin tick(); n++; end
        chk(tag, 32'(n), 32'(exp_n));
    endtask

    initial begin
        reset = 1'b0; valid_instr = 2'b00; i2c_mode = 8'h00; i2c_address = 8'h00;
        i2c_data = 16'h0000; cmd_done = 1'b0; cmd_nack = 1'b0; rx_byte = 8'h00;
        #2;
        chk("reset_outputs", {i2c_ready, cmd_valid, cmd_op, cmd_byte, result_valid,
                              result_default, result_error, busy},
            32'd0);
        chk("reset_result_data", 32'(result_data), 32'd0);
        #10 reset = 1'b1;
        tick();
        chk("ready_after_reset", 32'(i2c_ready), 32'd1);

        // Default poll, 2-byte read of register 0.
        push_cmd(3'd0, 8'h00); push_cmd(3'd2, 8'h90); push_cmd(3'd2, 8'h00);
        push_cmd(3'd1, 8'h00); push_cmd(3'd2, 8'h91); push_cmd(3'd3, 8'h00);
        push_cmd(3'd4, 8'h00); push_cmd(3'd5, 8'h00);
        exp_res.push_back('{d: 16'h1940, def: 1'b1, err: 1'b0});
        offer(2'b11, 8'h01, 8'h00, 16'h0000);
        tick(); valid_instr = 2'b00;
        chk("busy_in_txn", 32'(busy), 32'd1);
        serve(1'b0, 8'h00, 0); serve(1'b0, 8'h00, 0); serve(1'b0, 8'h00, 0);
        serve(1'b0, 8'h00, 0); serve(1'b0, 8'h00, 0);
        serve(1'b0, 8'h19, 0); serve(1'b0, 8'h40, 0); serve(1'b0, 8'h00, 0);
        check_result();
        ready_distance("poll_gap_length", PG + 1);

        // Queued 2-byte write with a 50-cycle engine stall on the high byte.
        push_cmd(3'd0, 8'h00); push_cmd(3'd2, 8'h90); push_cmd(3'd2, 8'h03);
        push_cmd(3'd2, 8'h4B); push_cmd(3'd2, 8'h00); push_cmd(3'd5, 8'h00);
        exp_res.push_back('{d: 16'h0000, def: 1'b0, err: 1'b0});
        offer(2'b01, 8'h04, 8'h03, 16'h4B00);
        tick(); valid_instr = 2'b00;
        serve(1'b0, 8'h00, 0); serve(1'b0, 8'h00, 0); serve(1'b0, 8'h00, 0);
        serve(1'b0, 8'h00, 50); serve(1'b0, 8'h00, 0); serve(1'b0, 8'h00, 0);
        check_result();
        ready_distance("queued_no_gap", 1);

        // NACK on the device-address write goes straight to STOP.
        push_cmd(3'd0, 8'h00); push_cmd(3'd2, 8'h90); push_cmd(3'd5, 8'h00);
        exp_res.push_back('{d: 16'h0000, def: 1'b0, err: 1'b1});
        offer(2'b01, 8'h00, 8'h05, 16'h0000);
        tick(); valid_instr = 2'b00;
        serve(1'b0, 8'h00, 0); serve(1'b1, 8'h00, 0); serve(1'b0, 8'h00, 0);
        check_result();
        ready_distance("nack_no_gap", 1);

        // 1-byte read: upper result byte must be zero.
        push_cmd(3'd0, 8'h00); push_cmd(3'd2, 8'h90); push_cmd(3'd2, 8'h01);
        push_cmd(3'd1, 8'h00); push_cmd(3'd2, 8'h91); push_cmd(3'd4, 8'h00);
        push_cmd(3'd5, 8'h00);
        exp_res.push_back('{d: 16'h007A, def: 1'b0, err: 1'b0});
        offer(2'b01, 8'h02, 8'h01, 16'h0000);
        tick(); valid_instr = 2'b00;
        serve(1'b0, 8'h00, 0); serve(1'b0, 8'h00, 0); serve(1'b0, 8'h00, 0);
        serve(1'b0, 8'h00, 0); serve(1'b0, 8'h00, 0); serve(1'b0, 8'h7A, 0);
        serve(1'b0, 8'h00, 0);
        check_result();
        ready_distance("read1_no_gap", 1);

        // Empty instruction in CAPTURE: immediate re-offer.
        offer(2'b00, 8'h00, 8'h00, 16'h0000);
        tick();
        chk("reoffer_after_empty", 32'(i2c_ready), 32'd1);
        chk("idle_not_busy", 32'(busy), 32'd0);

        // Illegal mode: no commands, result two cycles after CAPTURE.
        exp_res.push_back('{d: 16'h0000, def: 1'b0, err: 1'b1});
        offer(2'b01, 8'h06, 8'h00, 16'h0000);
        tick(); valid_instr = 2'b00;
        chk("illegal_early_result", 32'({cmd_valid, result_valid}), 32'd0);
        tick();
        chk("illegal_result_latency", 32'({cmd_valid, result_valid}), 32'd1);
        check_result();

        // Reset in the middle of RD_HI.
        push_cmd(3'd0, 8'h00); push_cmd(3'd2, 8'h90); push_cmd(3'd2, 8'h00);
        push_cmd(3'd1, 8'h00); push_cmd(3'd2, 8'h91); push_cmd(3'd3, 8'h00);
        offer(2'b01, 8'h01, 8'h00, 16'h0000);
        tick(); valid_instr = 2'b00;
        serve(1'b0, 8'h00, 0); serve(1'b0, 8'h00, 0); serve(1'b0, 8'h00, 0);
        serve(1'b0, 8'h00, 0); serve(1'b0, 8'h00, 0);
        wait_cmd();
        #2 reset = 1'b0;
        #1;
        chk("async_reset_outputs", {i2c_ready, cmd_valid, cmd_op, cmd_byte, result_valid,
                                    result_default, result_error, busy},
            32'd0);
        chk("async_reset_data", 32'(result_data), 32'd0);
        #2 reset = 1'b1;
        tick();
        chk("ready_after_rerelease", 32'(i2c_ready), 32'd1);
        tick();
        chk("ready_single_after_rerelease", 32'(i2c_ready), 32'd0);
        chk("scoreboard_cmd_empty", 32'(exp_cmd.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
